sw_line_unpacker: RTL and testbench

- Upstream feeder for the Smith-Waterman affine array top.
- Accepts 512-bit cache lines of database symbols from the memory-read path through a ready/valid handshake and buffers them in a small FIFO.
- Serializes each line into 64 one-byte symbols, one per cycle, as the downstream valid-qualified byte stream.
- Forwards the job's line count as a one-cycle configuration pulse, which the downstream uses for its done detection (count << 6 symbols).

---
 rtl/sw_pkg.sv | 21 ++
 rtl/sw_line_unpacker_if.sv | 35 +++
 rtl/sw_line_fifo.sv | 53 +++++
 rtl/sw_line_unpacker.sv | 140 ++++++++++++++
 tb/tb_sw_line_unpacker.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_pkg
// Brief    : Shared types and constants for the Smith-Waterman line feeder.
// Revision : 1.0 - initial release
// ============================================================================
package sw_pkg;

  // Unpacker control states
  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_DONE = 2'd2
  } t_unpack_state;

  // One cache line carries 64 symbols; downstream derives its symbol total as count << 6
  localparam int LINE_BYTES = 64;
  localparam int CL_SHIFT   = 6;

endpackage
`default_nettype wire

// File: rtl/sw_line_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module   : sw_line_unpacker_if
// Brief    : Job config, line-in handshake and symbol-out stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface sw_line_unpacker_if #(
  parameter int LINE_WIDTH = 512,
  parameter int SYM_WIDTH  = 8
);
  logic                  conf_in;
  logic [31:0]           count_in;
  logic [LINE_WIDTH-1:0] line_in;
  logic                  line_valid_in;
  logic                  line_ready_out;
  logic [SYM_WIDTH-1:0]  data_out;
  logic                  valid_out;
  logic                  conf_out;
  logic [31:0]           count_out;
  logic                  busy_out;
  logic                  done_out;

  // Upstream/consumer side
  modport master (
    output conf_in, count_in, line_in, line_valid_in,
    input  line_ready_out, data_out, valid_out, conf_out, count_out, busy_out, done_out
  );

  // Unpacker side
  modport slave (
    input  conf_in, count_in, line_in, line_valid_in,
    output line_ready_out, data_out, valid_out, conf_out, count_out, busy_out, done_out
  );
endinterface
`default_nettype wire

// File: rtl/sw_line_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sw_line_fifo
// Brief    : Register-array line buffer; the head entry is always presented
//            on rd_data so a pop and its consumer load share one clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module sw_line_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/sw_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : sw_line_unpacker
// Brief    : Buffers cache lines and serializes each into LSB-first symbols,
//            one per cycle, for the Smith-Waterman array; forwards job count.
// Revision : 1.0 - initial release
// ============================================================================
module sw_line_unpacker
  import sw_pkg::*;
#(
  parameter int LINE_WIDTH = 512,
  parameter int SYM_WIDTH  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  sw_line_unpacker_if.slave bus
);
  localparam int                  SYMS     = LINE_WIDTH / SYM_WIDTH;
  localparam int                  SYM_CW   = $clog2(SYMS);
  localparam logic [SYM_CW-1:0]   SYM_LAST = SYM_CW'(SYMS - 1);

  t_unpack_state         state;
  logic [31:0]           count;
  logic [31:0]           accepted;
  logic [31:0]           loaded;
  logic                  conf_q;
  logic                  busy_q;
  logic                  done_q;

  logic [LINE_WIDTH-1:0] shreg;
  logic                  sh_valid;
  logic [SYM_CW-1:0]     sym_cnt;
  logic                  sym_last;

  logic                  ready;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LINE_WIDTH-1:0] fifo_rd;
  logic                  job_end;

  // Ready depends on registered state only, so a same-cycle pop never feeds back into it
  assign ready     = (state == STATE_RUN) && !fifo_full && (accepted < count);
  assign fifo_push = bus.line_valid_in && ready;
  assign sym_last  = sh_valid && (sym_cnt == SYM_LAST);
  assign fifo_pop  = (state == STATE_RUN) && !fifo_empty && (!sh_valid || sym_last);
  // Last symbol of the final line leaves with nothing queued behind it
  assign job_end   = (state == STATE_RUN) && sym_last && fifo_empty && (loaded == count);

  sw_line_fifo #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (bus.line_in),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Job control FSM: conf capture, line accounting and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STATE_IDLE;
      count    <= '0;
      accepted <= '0;
      loaded   <= '0;
      conf_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      conf_q <= 1'b0;
      case (state)
        STATE_IDLE, STATE_DONE: begin
          if (bus.conf_in) begin
            count    <= bus.count_in;
            conf_q   <= 1'b1;
            accepted <= '0;
            loaded   <= '0;
            if (bus.count_in == 32'd0) begin
              state  <= STATE_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= STATE_RUN;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end
        end
        STATE_RUN: begin
          if (fifo_push) accepted <= accepted + 32'd1;
          if (fifo_pop)  loaded   <= loaded + 32'd1;
          if (job_end) begin
            state  <= STATE_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= STATE_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Shifter: load on pop, otherwise shift one symbol out per cycle while holding a line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      sh_valid <= 1'b0;
      sym_cnt  <= '0;
    end else if (fifo_pop) begin
      shreg    <= fifo_rd;
      sh_valid <= 1'b1;
      sym_cnt  <= '0;
    end else if (sh_valid) begin
      shreg   <= shreg >> SYM_WIDTH;
      sym_cnt <= sym_cnt + 1'b1;
      if (sym_last) sh_valid <= 1'b0;
    end
  end

  assign bus.line_ready_out = ready;
  assign bus.data_out       = shreg[SYM_WIDTH-1:0];
  assign bus.valid_out      = sh_valid;
  assign bus.conf_out       = conf_q;
  assign bus.count_out      = count;
  assign bus.busy_out       = busy_q;
  assign bus.done_out       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_line_unpacker
// Brief    : Directed bench for sw_line_unpacker with a schedule-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_line_unpacker;
  localparam int LW    = 512;
  localparam int SW    = 8;
  localparam int DEPTH = 2;
  localparam int SYMS  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sw_line_unpacker_if #(.LINE_WIDTH(LW), .SYM_WIDTH(SW)) bus ();

  sw_line_unpacker #(
    .LINE_WIDTH (LW),
    .SYM_WIDTH  (SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [7:0] base);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < SYMS; k++) r[SW*k +: SW] = base + 8'(k);
    return r;
  endfunction

  // Model: each accepted line is scheduled to start at max(handshake+2, previous end+1)
  int            m_state;  // 0 idle, 1 run, 2 done
  logic [31:0]   m_count;
  bit            m_conf;
  int            m_acc;
  int            m_prev_end;
  logic [LW-1:0] q_data[$];
  int            q_hs[$];
  int            q_start[$];

  int run_len   = 0;
  int max_run   = 0;
  int vld_count = 0;
  int dut_hs    = 0;

  always @(negedge clk) begin : monitor
    int            t;
    int            occ;
    int            st;
    bit            e_valid;
    logic [7:0]    e_data;
    bit            e_ready;
    logic [LW-1:0] ln;
    t = cyc;
    if (rst) begin
      chk("rst_valid", bus.valid_out, 0);
      chk("rst_data", bus.data_out, 0);
      chk("rst_conf", bus.conf_out, 0);
      chk("rst_count", bus.count_out, 0);
      chk("rst_busy", bus.busy_out, 0);
      chk("rst_done", bus.done_out, 0);
      chk("rst_ready", bus.line_ready_out, 0);
      m_state = 0; m_count = '0; m_conf = 0; m_acc = 0; m_prev_end = 0;
      q_data.delete(); q_hs.delete(); q_start.delete();
      run_len = 0;
    end else begin
      occ = 0; e_valid = 0; e_data = '0;
      for (int i = 0; i < q_start.size(); i++) begin
        if (q_hs[i] + 1 <= t && t <= q_start[i] - 1) occ++;
        if (q_start[i] <= t && t <= q_start[i] + SYMS - 1) begin
          ln      = q_data[i];
          e_valid = 1;
          e_data  = ln[SW*(t - q_start[i]) +: SW];
        end
      end
      e_ready = (m_state == 1) && (occ < DEPTH) && (m_acc < int'(m_count));
      chk("mon_conf_out", bus.conf_out, m_conf);
      chk("mon_count_out", bus.count_out, m_count);
      chk("mon_busy", bus.busy_out, m_state == 1);
      chk("mon_done", bus.done_out, m_state == 2);
      chk("mon_ready", bus.line_ready_out, e_ready);
      chk("mon_valid", bus.valid_out, e_valid);
      if (e_valid) chk("mon_data", bus.data_out, e_data);

      if (bus.valid_out) begin
        vld_count++; run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (bus.line_valid_in && bus.line_ready_out) dut_hs++;

      m_conf = 0;
      if (m_state != 1 && bus.conf_in) begin
        m_count = bus.count_in; m_conf = 1; m_acc = 0; m_prev_end = 0;
        q_data.delete(); q_hs.delete(); q_start.delete();
        m_state = (bus.count_in == 32'd0) ? 2 : 1;
      end else if (m_state == 1) begin
        if (bus.line_valid_in && e_ready) begin
          st = (t + 2 > m_prev_end + 1) ? t + 2 : m_prev_end + 1;
          q_data.push_back(bus.line_in); q_hs.push_back(t); q_start.push_back(st);
          m_prev_end = st + SYMS - 1;
          m_acc++;
        end
        if (m_acc == int'(m_count) && q_start.size() > 0 && t == m_prev_end) m_state = 2;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_conf(input int c);
    bus.conf_in = 1'b1; bus.count_in = c;
    tick();
    bus.conf_in = 1'b0;
    #1;
    chk("conf_pulse", bus.conf_out, 1);
    chk("conf_count_out", bus.count_out, c);
  endtask

  task automatic send_line(input logic [LW-1:0] d, input bit hold, output int hs);
    bus.line_in = d; bus.line_valid_in = 1'b1; hs = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.line_ready_out) begin hs = cyc; break; end
    end
    if (hs < 0) begin
      n_checks++;
      $display("FAIL handshake_timeout: line_ready_out stayed low for 2000 cycles");
      bus.line_valid_in = 1'b0;
    end else begin
      tick();
      if (!hold) bus.line_valid_in = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int x);
    for (int i = 0; i < 5000 && cyc < x; i++) @(negedge clk);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (bus.done_out) break;
      @(negedge clk);
    end
    chk("done_reached", bus.done_out, 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hs, hs0, hs_before;
    bus.conf_in = 1'b0; bus.count_in = '0; bus.line_in = '0; bus.line_valid_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", bus.busy_out, 0);
    chk("idle_done", bus.done_out, 0);

    // Single line: bytes 0x00..0x3F
    do_conf(1);
    send_line(mk_line(8'h00), 1'b0, hs);
    chk("ready_after_accept", bus.line_ready_out, 0);
    chk("no_sym_at_hs1", bus.valid_out, 0);
    wait_cyc(hs + 2);
    chk("single_sym0_valid", bus.valid_out, 1);
    chk("single_sym0", bus.data_out, 8'h00);
    wait_cyc(hs + 65);
    chk("single_sym63", bus.data_out, 8'h3F);
    wait_cyc(hs + 66);
    chk("single_done", bus.done_out, 1);
    chk("single_valid_off", bus.valid_out, 0);

    // Streaming: four lines with valid held high, extra line offered afterwards
    do_conf(4);
    vld_count = 0; max_run = 0; hs_before = dut_hs;
    for (int i = 0; i < 4; i++) send_line(mk_line(8'(16 * i)), 1'b1, hs);
    bus.line_in = mk_line(8'hEE);
    wait_done(400);
    bus.line_valid_in = 1'b0;
    chk("stream_handshakes", dut_hs - hs_before, 4);
    chk("stream_symbols", vld_count, 256);
    chk("stream_gapless", max_run, 256);

    // Throttled upstream: each burst starts two cycles after its handshake
    do_conf(3);
    for (int i = 0; i < 3; i++) begin
      repeat (100) tick();
      send_line(mk_line(8'(8'h40 + i)), 1'b0, hs);
      chk("thr_gap", bus.valid_out, 0);
      wait_cyc(hs + 2);
      chk("thr_burst_valid", bus.valid_out, 1);
      chk("thr_burst_sym0", bus.data_out, 8'(8'h40 + i));
    end
    wait_cyc(hs + 65);
    chk("thr_not_done_yet", bus.done_out, 0);
    wait_cyc(hs + 66);
    chk("thr_done", bus.done_out, 1);

    // Zero-line job finishes immediately and accepts nothing
    do_conf(0);
    chk("zero_done", bus.done_out, 1);
    hs_before = dut_hs;
    bus.line_valid_in = 1'b1;
    repeat (5) tick();
    chk("zero_ready", bus.line_ready_out, 0);
    bus.line_valid_in = 1'b0;
    chk("zero_no_hs", dut_hs - hs_before, 0);

    // conf during RUN is ignored
    do_conf(2);
    send_line(mk_line(8'h60), 1'b0, hs);
    wait_cyc(hs + 10);
    bus.conf_in = 1'b1; bus.count_in = 9;
    tick();
    bus.conf_in = 1'b0;
    #1;
    chk("midrun_no_conf", bus.conf_out, 0);
    chk("midrun_count_kept", bus.count_out, 2);
    send_line(mk_line(8'h80), 1'b0, hs);
    wait_done(300);
    chk("midrun_final_count", bus.count_out, 2);

    // Reset at symbol 20 of the third line of a four-line job
    do_conf(4);
    send_line(mk_line(8'h00), 1'b1, hs0);
    send_line(mk_line(8'h10), 1'b1, hs);
    send_line(mk_line(8'h20), 1'b1, hs);
    bus.line_in = mk_line(8'h30);
    wait_cyc(hs0 + 150);
    chk("pre_rst_valid", bus.valid_out, 1);
    chk("pre_rst_sym20", bus.data_out, 8'h34);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.valid_out, 0);
    chk("async_rst_data", bus.data_out, 0);
    chk("async_rst_busy", bus.busy_out, 0);
    chk("async_rst_count", bus.count_out, 0);
    chk("async_rst_ready", bus.line_ready_out, 0);
    bus.line_valid_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    vld_count = 0;
    do_conf(1);
    send_line(mk_line(8'hA0), 1'b0, hs);
    wait_cyc(hs + 2);
    chk("post_rst_sym0", bus.data_out, 8'hA0);
    wait_done(200);
    chk("post_rst_symbols", vld_count, 64);

    // Restart from DONE
    do_conf(2);
    send_line(mk_line(8'hC0), 1'b0, hs);
    send_line(mk_line(8'hD0), 1'b0, hs);
    wait_done(300);
    vld_count = 0;
    do_conf(1);
    chk("restart_done_drops", bus.done_out, 0);
    send_line(mk_line(8'h05), 1'b0, hs);
    wait_done(200);
    chk("restart_symbols", vld_count, 64);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
